// File: rtl/uart_cmd_decoder.sv
// Decodes 5-byte SYNC/CMD/ADDR/DATA/CHK frames from the UART receive FIFO into
// register write/read strobes and pushes a 2-byte status response to the transmit FIFO.
module uart_cmd_decoder #(
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter int unsigned TIMEOUT   = 12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_nxt,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_full,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] err_cnt
);

    typedef enum logic [3:0] {
        HUNT = 4'd0,
        CMD  = 4'd1,
        ADDR = 4'd2,
        DATA = 4'd3,
        CHK  = 4'd4,
        WR   = 4'd5,
        RD   = 4'd6,
        RDL  = 4'd7,
        ERR  = 4'd8,
        RSP0 = 4'd9,
        RSP1 = 4'd10
    } state_t;

    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic        rx_nxt_r, rx_nxt_s;
    logic        vld_r;
    logic [23:0] tmo_cnt_r, tmo_cnt_s;
    logic [7:0]  cmd_r, cmd_s;
    logic [7:0]  code_r, code_s;
    logic [7:0]  rsp0_r, rsp0_s;
    logic [7:0]  rsp1_r, rsp1_s;
    logic [7:0]  reg_addr_r, reg_addr_s;
    logic [7:0]  reg_wdata_r, reg_wdata_s;
    logic        reg_wr_r, reg_wr_s;
    logic        reg_rd_r, reg_rd_s;
    logic        tx_wr_r, tx_wr_s;
    logic [7:0]  tx_data_r, tx_data_s;
    logic        busy_r, busy_s;
    logic [7:0]  err_cnt_r, err_cnt_s;
    logic        take_s;
    logic        frame_s;
    logic        tmo_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    function automatic logic is_rx_state(input state_t s);
        is_rx_state = (s == HUNT) || (s == CMD) || (s == ADDR) || (s == DATA) || (s == CHK);
    endfunction

    // A byte is consumable in the cycle after its pop; timeout only counts inside a frame.
    always_comb begin
        take_s  = vld_r && is_rx_state(state_r);
        frame_s = (state_r == CMD) || (state_r == ADDR) || (state_r == DATA) || (state_r == CHK);
        tmo_s   = frame_s && !take_s && (tmo_cnt_r == TMO_LAST);
    end

    // Next-state and next-output logic for the frame decoder.
    always_comb begin
        state_s     = state_r;
        cmd_s       = cmd_r;
        code_s      = code_r;
        rsp0_s      = rsp0_r;
        rsp1_s      = rsp1_r;
        reg_addr_s  = reg_addr_r;
        reg_wdata_s = reg_wdata_r;
        tx_wr_s     = 1'b0;
        tx_data_s   = tx_data_r;
        err_cnt_s   = err_cnt_r;
        if (frame_s && !take_s) begin
            tmo_cnt_s = tmo_cnt_r + 24'd1;
        end else begin
            tmo_cnt_s = 24'd0;
        end
        case (state_r)
            HUNT: begin
                if (take_s && (rx_data == SYNC_BYTE)) begin
                    state_s = CMD;
                end else begin
                    state_s = HUNT;
                end
            end
            CMD: begin
                if (take_s) begin
                    cmd_s   = rx_data;
                    state_s = ADDR;
                end else if (tmo_s) begin
                    err_cnt_s = sat_inc(err_cnt_r);
                    state_s   = HUNT;
                end else begin
                    state_s = CMD;
                end
            end
            ADDR: begin
                if (take_s) begin
                    reg_addr_s = rx_data;
                    state_s    = DATA;
                end else if (tmo_s) begin
                    err_cnt_s = sat_inc(err_cnt_r);
                    state_s   = HUNT;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (take_s) begin
                    reg_wdata_s = rx_data;
                    state_s     = CHK;
                end else if (tmo_s) begin
                    err_cnt_s = sat_inc(err_cnt_r);
                    state_s   = HUNT;
                end else begin
                    state_s = DATA;
                end
            end
            CHK: begin
                if (take_s) begin
                    if (rx_data != (cmd_r ^ reg_addr_r ^ reg_wdata_r)) begin
                        code_s  = 8'h01;
                        state_s = ERR;
                    end else if (cmd_r == 8'h01) begin
                        state_s = WR;
                    end else if (cmd_r == 8'h02) begin
                        state_s = RD;
                    end else begin
                        code_s  = 8'h02;
                        state_s = ERR;
                    end
                end else if (tmo_s) begin
                    err_cnt_s = sat_inc(err_cnt_r);
                    state_s   = HUNT;
                end else begin
                    state_s = CHK;
                end
            end
            WR: begin
                rsp0_s  = 8'hAA;
                rsp1_s  = 8'h00;
                state_s = RSP0;
            end
            RD: begin
                state_s = RDL;
            end
            RDL: begin
                rsp0_s  = 8'hAA;
                rsp1_s  = reg_rdata;
                state_s = RSP0;
            end
            ERR: begin
                err_cnt_s = sat_inc(err_cnt_r);
                rsp0_s    = 8'hEE;
                rsp1_s    = code_r;
                state_s   = RSP0;
            end
            RSP0: begin
                if (!tx_full) begin
                    tx_wr_s   = 1'b1;
                    tx_data_s = rsp0_r;
                    state_s   = RSP1;
                end else begin
                    state_s = RSP0;
                end
            end
            RSP1: begin
                // Skip one cycle after the first push so tx_full reflects it.
                if (!tx_full && !tx_wr_r) begin
                    tx_wr_s   = 1'b1;
                    tx_data_s = rsp1_r;
                    state_s   = HUNT;
                end else begin
                    state_s = RSP1;
                end
            end
            default: begin
                state_s = HUNT;
            end
        endcase
        reg_wr_s = (state_s == WR);
        reg_rd_s = (state_s == RD);
        busy_s   = (state_s != HUNT);
        rx_nxt_s = is_rx_state(state_s) && !rx_empty && !rx_nxt_r && !vld_r;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= HUNT;
            rx_nxt_r    <= 1'b0;
            vld_r       <= 1'b0;
            tmo_cnt_r   <= 24'd0;
            cmd_r       <= 8'h00;
            code_r      <= 8'h00;
            rsp0_r      <= 8'h00;
            rsp1_r      <= 8'h00;
            reg_addr_r  <= 8'h00;
            reg_wdata_r <= 8'h00;
            reg_wr_r    <= 1'b0;
            reg_rd_r    <= 1'b0;
            tx_wr_r     <= 1'b0;
            tx_data_r   <= 8'h00;
            busy_r      <= 1'b0;
            err_cnt_r   <= 8'h00;
        end else begin
            state_r     <= state_s;
            rx_nxt_r    <= rx_nxt_s;
            vld_r       <= rx_nxt_r;
            tmo_cnt_r   <= tmo_cnt_s;
            cmd_r       <= cmd_s;
            code_r      <= code_s;
            rsp0_r      <= rsp0_s;
            rsp1_r      <= rsp1_s;
            reg_addr_r  <= reg_addr_s;
            reg_wdata_r <= reg_wdata_s;
            reg_wr_r    <= reg_wr_s;
            reg_rd_r    <= reg_rd_s;
            tx_wr_r     <= tx_wr_s;
            tx_data_r   <= tx_data_s;
            busy_r      <= busy_s;
            err_cnt_r   <= err_cnt_s;
        end
    end

    assign rx_nxt    = rx_nxt_r;
    assign tx_data   = tx_data_r;
    assign tx_wr     = tx_wr_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_wr    = reg_wr_r;
    assign reg_rd    = reg_rd_r;
    assign busy      = busy_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: FIFO/register models, table vectors, corner sequences,
// and random frame streams checked against a frame-level reference model.
module tb_uart_cmd_decoder;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_empty;
    logic       rx_nxt;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic [7:0] err_cnt;

    uart_cmd_decoder #(.SYNC_BYTE(8'h55), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_nxt(rx_nxt),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Receive FIFO model
    logic [7:0] rx_mem [0:4095];
    int push_cnt = 0;
    int pop_cnt  = 0;
    assign rx_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (rx_nxt && !rx_empty) begin
            rx_data <= rx_mem[pop_cnt % 4096];
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Register file model: read data is a fixed function of the address, valid one cycle after reg_rd
    always @(posedge clk) begin
        reg_rdata <= reg_rd ? (reg_addr ^ 8'h7A) : 8'h00;
    end

    logic hold_full = 1'b0;
    logic rand_bp   = 1'b0;
    always @(negedge clk) begin
        tx_full <= hold_full | (rand_bp & ($urandom_range(0, 3) == 0));
    end

    // Bus monitor
    int cyc = 0, wr_n = 0, rd_n = 0, tx_n = 0, both_n = 0, viol_n = 0, wr_c = 0;
    logic [7:0] wr_a [0:1023];
    logic [7:0] wr_d [0:1023];
    logic [7:0] rd_a [0:1023];
    logic [7:0] tx_b [0:2047];
    int         tx_c [0:2047];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reg_wr) begin
            wr_a[wr_n % 1024] <= reg_addr;
            wr_d[wr_n % 1024] <= reg_wdata;
            wr_c <= cyc;
            wr_n <= wr_n + 1;
        end
        if (reg_rd) begin
            rd_a[rd_n % 1024] <= reg_addr;
            rd_n <= rd_n + 1;
        end
        if (tx_wr) begin
            tx_b[tx_n % 2048] <= tx_data;
            tx_c[tx_n % 2048] <= cyc;
            tx_n <= tx_n + 1;
        end
        if (reg_wr && reg_rd) both_n <= both_n + 1;
        if (rx_nxt && rx_empty) viol_n <= viol_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[push_cnt % 4096] = b;
        push_cnt = push_cnt + 1;
    endtask

    task automatic wait_tx(input string name, input int target, input int bound);
        int k;
        k = 0;
        while (tx_n < target && k < bound) begin
            step(1);
            k++;
        end
        check({name, "_tx_arrive"}, int'(tx_n >= target), 1);
    endtask

    typedef struct {
        logic [39:0] b;
        int          wr;
        int          rd;
        logic [7:0]  t0;
        logic [7:0]  t1;
        int          err;
    } vec_t;

    vec_t tbl [8];

    task automatic run_vec(input string name, input vec_t v);
        int w0, r0, t0, e0;
        w0 = wr_n; r0 = rd_n; t0 = tx_n; e0 = int'(err_cnt);
        for (int i = 4; i >= 0; i--) push(v.b[i*8 +: 8]);
        wait_tx(name, t0 + 2, 300);
        step(3);
        check({name, "_wr_count"}, wr_n - w0, v.wr);
        check({name, "_rd_count"}, rd_n - r0, v.rd);
        check({name, "_tx0"}, int'(tx_b[t0 % 2048]), int'(v.t0));
        check({name, "_tx1"}, int'(tx_b[(t0 + 1) % 2048]), int'(v.t1));
        check({name, "_err_inc"}, int'(err_cnt) - e0, v.err);
        check({name, "_busy_idle"}, int'(busy), 0);
        if (v.wr != 0) begin
            check({name, "_wr_addr"}, int'(wr_a[w0 % 1024]), int'(v.b[23:16]));
            check({name, "_wr_data"}, int'(wr_d[w0 % 1024]), int'(v.b[15:8]));
            check({name, "_wr_to_tx"}, tx_c[t0 % 2048] - wr_c, 2);
        end
        if (v.rd != 0) begin
            check({name, "_rd_addr"}, int'(rd_a[r0 % 1024]), int'(v.b[23:16]));
        end
    endtask

    // Random-stream reference model state
    logic [7:0] strm [$];
    logic [7:0] ex_wa [$];
    logic [7:0] ex_wd [$];
    logic [7:0] ex_ra [$];
    logic [7:0] ex_tx [$];
    int         ex_err;

    task automatic model_stream();
        int i;
        logic [7:0] c, a, d, k;
        i = 0;
        ex_err = 0;
        while (i < strm.size()) begin
            if (strm[i] != 8'h55 || i + 4 >= strm.size()) begin
                i++;
            end else begin
                c = strm[i+1]; a = strm[i+2]; d = strm[i+3]; k = strm[i+4];
                if (k != (c ^ a ^ d)) begin
                    ex_tx.push_back(8'hEE); ex_tx.push_back(8'h01); ex_err++;
                end else if (c == 8'h01) begin
                    ex_wa.push_back(a); ex_wd.push_back(d);
                    ex_tx.push_back(8'hAA); ex_tx.push_back(8'h00);
                end else if (c == 8'h02) begin
                    ex_ra.push_back(a);
                    ex_tx.push_back(8'hAA); ex_tx.push_back(a ^ 8'h7A);
                end else begin
                    ex_tx.push_back(8'hEE); ex_tx.push_back(8'h02); ex_err++;
                end
                i += 5;
            end
        end
    endtask

    int w0, r0, t0, e0, nfr;
    logic [7:0] c, a, d, k, j;
    vec_t wvec;

    initial begin
        tbl[0] = '{40'h55_01_10_3C_2D, 1, 0, 8'hAA, 8'h00, 0};
        tbl[1] = '{40'h55_02_20_00_22, 0, 1, 8'hAA, 8'h5A, 0};
        tbl[2] = '{40'h55_01_10_3C_00, 0, 0, 8'hEE, 8'h01, 1};
        tbl[3] = '{40'h55_07_00_00_07, 0, 0, 8'hEE, 8'h02, 1};
        tbl[4] = '{40'h55_01_FF_A5_5B, 1, 0, 8'hAA, 8'h00, 0};
        tbl[5] = '{40'h55_02_FF_00_FD, 0, 1, 8'hAA, 8'h85, 0};
        tbl[6] = '{40'h55_02_20_00_23, 0, 0, 8'hEE, 8'h01, 1};
        tbl[7] = '{40'h55_00_00_00_00, 0, 0, 8'hEE, 8'h02, 1};
        wvec   = tbl[0];

        step(3);
        check("reset_outputs",
              int'({rx_nxt, tx_wr, tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err_cnt} != 0), 0);
        rst = 1'b1;
        step(3);
        check("idle_no_fetch", int'(rx_nxt), 0);

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Garbage then abandoned frame: timeout drops it silently
        e0 = int'(err_cnt); t0 = tx_n; w0 = wr_n;
        push(8'h00); push(8'hFF); push(8'h55); push(8'h01);
        step(30);
        check("tmo_busy_mid", int'(busy), 1);
        step(TMO + 20);
        check("tmo_err_inc", int'(err_cnt) - e0, 1);
        check("tmo_no_tx", tx_n - t0, 0);
        check("tmo_no_wr", wr_n - w0, 0);
        check("tmo_hunt", int'(busy), 0);
        run_vec("after_tmo", wvec);

        // Gap shorter than the timeout still completes the frame
        e0 = int'(err_cnt); t0 = tx_n; w0 = wr_n;
        push(8'h55); push(8'h01);
        step(TMO - 40);
        push(8'h10); push(8'h3C); push(8'h2D);
        wait_tx("near_tmo", t0 + 2, 300);
        step(3);
        check("near_tmo_wr", wr_n - w0, 1);
        check("near_tmo_err", int'(err_cnt) - e0, 0);

        // Backpressure holds the response until tx_full drops
        hold_full = 1'b1;
        t0 = tx_n; w0 = wr_n;
        for (int i = 4; i >= 0; i--) push(wvec.b[i*8 +: 8]);
        step(40);
        check("bp_wr_done", wr_n - w0, 1);
        check("bp_no_tx", tx_n - t0, 0);
        check("bp_busy_held", int'(busy), 1);
        hold_full = 1'b0;
        wait_tx("bp", t0 + 2, 100);
        step(3);
        check("bp_tx0", int'(tx_b[t0 % 2048]), 8'hAA);
        check("bp_tx1", int'(tx_b[(t0 + 1) % 2048]), 8'h00);
        check("bp_busy_idle", int'(busy), 0);

        // Random frame stream with random backpressure
        rand_bp = 1'b1;
        strm.delete(); ex_wa.delete(); ex_wd.delete(); ex_ra.delete(); ex_tx.delete();
        w0 = wr_n; r0 = rd_n; t0 = tx_n; e0 = int'(err_cnt);
        nfr = 40;
        for (int f = 0; f < nfr; f++) begin
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'h55) j = 8'h54;
                strm.push_back(j);
            end
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: begin c = 8'h01; k = c ^ a ^ d; end
                1: begin c = 8'h02; k = c ^ a ^ d; end
                2: begin c = 8'($urandom_range(1, 2)); k = c ^ a ^ d ^ 8'($urandom_range(1, 255)); end
                default: begin
                    c = 8'($urandom_range(0, 255));
                    if (c == 8'h01 || c == 8'h02) c = c + 8'h10;
                    k = c ^ a ^ d;
                end
            endcase
            strm.push_back(8'h55); strm.push_back(c); strm.push_back(a);
            strm.push_back(d); strm.push_back(k);
        end
        model_stream();
        foreach (strm[i]) push(strm[i]);
        wait_tx("rand", t0 + ex_tx.size(), nfr * 100);
        step(5);
        rand_bp = 1'b0;
        check("rand_tx_count", tx_n - t0, ex_tx.size());
        check("rand_wr_count", wr_n - w0, ex_wa.size());
        check("rand_rd_count", rd_n - r0, ex_ra.size());
        check("rand_err", int'(err_cnt) - e0, ex_err);
        foreach (ex_tx[i]) check($sformatf("rand_tx%0d", i), int'(tx_b[(t0 + i) % 2048]), int'(ex_tx[i]));
        foreach (ex_wa[i]) begin
            check($sformatf("rand_wa%0d", i), int'(wr_a[(w0 + i) % 1024]), int'(ex_wa[i]));
            check($sformatf("rand_wd%0d", i), int'(wr_d[(w0 + i) % 1024]), int'(ex_wd[i]));
        end
        foreach (ex_ra[i]) check($sformatf("rand_ra%0d", i), int'(rd_a[(r0 + i) % 1024]), int'(ex_ra[i]));

        // Reset in the middle of a frame aborts it
        check("pre_rst_err_nonzero", int'(err_cnt != 8'h00), 1);
        w0 = wr_n; t0 = tx_n;
        push(8'h55); push(8'h01); push(8'h10);
        step(12);
        check("midframe_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("midframe_rst_outputs",
              int'({rx_nxt, tx_wr, tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err_cnt} != 0), 0);
        step(3);
        rst = 1'b1;
        push(8'h3C); push(8'h2D);
        step(30);
        check("midframe_no_wr", wr_n - w0, 0);
        check("midframe_no_tx", tx_n - t0, 0);
        check("midframe_idle", int'(busy), 0);

        // err_cnt saturates at FF
        t0 = tx_n;
        for (int f = 0; f < 260; f++) begin
            push(8'h55); push(8'h01); push(8'h10); push(8'h3C); push(8'h00);
        end
        wait_tx("sat", t0 + 520, 260 * 60);
        step(3);
        check("err_saturated", int'(err_cnt), 8'hFF);

        check("wr_rd_overlap", both_n, 0);
        check("rx_nxt_when_empty", viol_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
